uart_rx_line_buffer: RTL and testbench

Synthesizable, parametrised UART receiver for the RISC-V top. It recovers serial frames from the board RX line, checks parity and stop bits, and buffers good characters in a FIFO. Characters leave on a valid/ready stream, with end-of-line tagging and a line counter. It replaces bench-only serial monitoring with an on-chip block. Supported modes are 5–8 data bits, none/even/odd parity and 1 or 2 stop bits.

---
 rtl/uart_rx_line_buffer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_rx_line_buffer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_line_buffer.sv
// UART receiver (5-8 data bits, none/even/odd parity, 1-2 stop bits) feeding a
// first-word-fall-through character FIFO with end-of-line tagging and a line counter.
module uart_rx_line_buffer #(
  parameter int         CLK_FREQ_HZ = 70_000_000,
  parameter int         BAUDRATE    = 1_000_000,
  parameter int         DATA_BITS   = 8,
  parameter int         PARITY      = 1,
  parameter int         STOP_BITS   = 1,
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] EOL_CHAR    = 8'h0A
) (
  input  logic                             sys_clk,
  input  logic                             sys_rstn,
  input  logic                             uart_rxd,
  output logic [DATA_BITS-1:0]             m_data,
  output logic                             m_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic [15:0]                      line_cnt,
  output logic                             err_parity,
  output logic                             err_frame,
  output logic                             err_overflow,
  output logic                             busy
);

  localparam int DIV = CLK_FREQ_HZ / BAUDRATE;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam int BW  = 3;
  localparam logic                 ODD_P = (PARITY == 2);
  localparam logic [DATA_BITS-1:0] EOL   = EOL_CHAR[DATA_BITS-1:0];

  generate
    if (DIV < 4) begin : g_div_check
      $error("uart_rx_line_buffer: CLK_FREQ_HZ/BAUDRATE must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_check
      $error("uart_rx_line_buffer: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_par_check
      $error("uart_rx_line_buffer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
      $error("uart_rx_line_buffer: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_depth_check
      $error("uart_rx_line_buffer: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic                 rx_meta;
  logic                 rxs;
  logic                 rxs_d;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_err_reg, par_err_next;
  logic                 stop_bad_reg, stop_bad_next;
  logic                 push_reg, push_next;
  logic [DATA_BITS-1:0] char_reg, char_next;
  logic                 err_parity_reg, err_parity_next;
  logic                 err_frame_reg, err_frame_next;
  logic                 tick;

  assign tick = (cnt_reg == '0);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    bit_next        = bit_reg;
    shift_next      = shift_reg;
    par_err_next    = par_err_reg;
    stop_bad_next   = stop_bad_reg;
    push_next       = 1'b0;
    char_next       = char_reg;
    err_parity_next = 1'b0;
    err_frame_next  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (rxs_d && !rxs) begin
          state_next = S_START;
          cnt_next   = CW'(DIV / 2 - 1);
        end
      end

      S_START: begin
        if (!tick) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (rxs) begin
          err_frame_next = 1'b1;
          state_next     = S_IDLE;
        end else begin
          state_next    = S_DATA;
          cnt_next      = CW'(DIV - 1);
          bit_next      = '0;
          par_err_next  = 1'b0;
          stop_bad_next = 1'b0;
        end
      end

      S_DATA: begin
        if (!tick) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          shift_next = {rxs, shift_reg[DATA_BITS-1:1]};
          cnt_next   = CW'(DIV - 1);
          if (bit_reg == BW'(DATA_BITS - 1)) begin
            bit_next   = '0;
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (!tick) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          // Even: data^parity must be 0; odd: must be 1.
          par_err_next = (^shift_reg) ^ rxs ^ ODD_P;
          cnt_next     = CW'(DIV - 1);
          bit_next     = '0;
          state_next   = S_STOP;
        end
      end

      S_STOP: begin
        if (!tick) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (bit_reg == BW'(STOP_BITS - 1)) begin
          if (stop_bad_reg || !rxs) begin
            err_frame_next = 1'b1;
            state_next     = S_WAIT_IDLE;
          end else if (par_err_reg) begin
            err_parity_next = 1'b1;
            state_next      = S_IDLE;
          end else begin
            push_next  = 1'b1;
            char_next  = shift_reg;
            state_next = S_IDLE;
          end
        end else begin
          stop_bad_next = stop_bad_reg | ~rxs;
          bit_next      = bit_reg + 1'b1;
          cnt_next      = CW'(DIV - 1);
        end
      end

      S_WAIT_IDLE: begin
        // A held-low break stays here, so it reports only one framing error.
        if (rxs) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rx_meta        <= 1'b1;
      rxs            <= 1'b1;
      rxs_d          <= 1'b1;
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      bit_reg        <= '0;
      shift_reg      <= '0;
      par_err_reg    <= 1'b0;
      stop_bad_reg   <= 1'b0;
      push_reg       <= 1'b0;
      char_reg       <= '0;
      err_parity_reg <= 1'b0;
      err_frame_reg  <= 1'b0;
    end else begin
      rx_meta        <= uart_rxd;
      rxs            <= rx_meta;
      rxs_d          <= rxs;
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_reg        <= bit_next;
      shift_reg      <= shift_next;
      par_err_reg    <= par_err_next;
      stop_bad_reg   <= stop_bad_next;
      push_reg       <= push_next;
      char_reg       <= char_next;
      err_parity_reg <= err_parity_next;
      err_frame_reg  <= err_frame_next;
    end
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [LW-1:0]        count_reg;
  logic [15:0]          line_cnt_reg;
  logic                 err_overflow_reg;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 push_ok;
  logic [DATA_BITS-1:0] head;

  assign fifo_full  = (count_reg == LW'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign pop        = !fifo_empty && m_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = push_reg && (!fifo_full || pop);
  assign head       = mem[rd_ptr_reg];

  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= char_reg;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      line_cnt_reg     <= '0;
      err_overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + LW'(push_ok) - LW'(pop);
      if (push_ok && (char_reg == EOL)) begin
        line_cnt_reg <= line_cnt_reg + 16'd1;
      end
      err_overflow_reg <= push_reg && fifo_full && !pop;
    end
  end

  assign m_valid      = !fifo_empty;
  assign m_data       = fifo_empty ? '0 : head;
  assign m_last       = !fifo_empty && (head == EOL);
  assign fifo_level   = count_reg;
  assign line_cnt     = line_cnt_reg;
  assign err_parity   = err_parity_reg;
  assign err_frame    = err_frame_reg;
  assign err_overflow = err_overflow_reg;
  assign busy         = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_line_buffer.sv
// Bench for uart_rx_line_buffer: default 8E1 instance plus a 7O2 instance, serial frames
// built bit by bit, a character queue model and pulse counters checked after each frame.
`timescale 1ns/1ps
module tb_uart_rx_line_buffer;
  localparam int DIV   = 70;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #7 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        rxd0 = 1'b1;
  logic        rxd1 = 1'b1;
  logic        m_ready0 = 1'b0;
  logic        m_ready1 = 1'b0;
  logic [7:0]  data0;
  logic [6:0]  data1;
  logic        last0, last1, valid0, valid1;
  logic [4:0]  level0, level1;
  logic [15:0] lcnt0, lcnt1;
  logic        perr0, ferr0, oerr0, busy0;
  logic        perr1, ferr1, oerr1, busy1;

  uart_rx_line_buffer u_dut (
    .sys_clk(clk), .sys_rstn(rst_n), .uart_rxd(rxd0),
    .m_data(data0), .m_last(last0), .m_valid(valid0), .m_ready(m_ready0),
    .fifo_level(level0), .line_cnt(lcnt0),
    .err_parity(perr0), .err_frame(ferr0), .err_overflow(oerr0), .busy(busy0)
  );

  uart_rx_line_buffer #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut7 (
    .sys_clk(clk), .sys_rstn(rst_n), .uart_rxd(rxd1),
    .m_data(data1), .m_last(last1), .m_valid(valid1), .m_ready(m_ready1),
    .fifo_level(level1), .line_cnt(lcnt1),
    .err_parity(perr1), .err_frame(ferr1), .err_overflow(oerr1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: queue of characters that must leave the stream, plus event counts.
  logic [7:0] exp_q[$];
  int exp_par = 0, exp_frm = 0, exp_ovf = 0, exp_line = 0;
  int obs_par = 0, obs_frm = 0, obs_ovf = 0, obs_par1 = 0, obs_frm1 = 0;
  int ready_mode = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready0 = 1'b0;
      1:       m_ready0 = 1'b1;
      default: m_ready0 = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (perr0) obs_par++;
      if (ferr0) obs_frm++;
      if (oerr0) obs_ovf++;
      if (perr1) obs_par1++;
      if (ferr1) obs_frm1++;
      if (valid0 && m_ready0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: got %0h expected no character", data0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("stream_data", data0, e);
          chk("stream_last", last0, e == 8'h0A);
        end
      end
      if (prev_hold && valid0) chk("hold_stable", data0, prev_data);
      prev_hold = valid0 && !m_ready0;
      prev_data = data0;
    end
  end

  task automatic drive_bit(input int inst, input logic b, input int n);
    if (inst == 0) rxd0 = b;
    else rxd1 = b;
    repeat (n) @(negedge clk);
  endtask

  // Instance 0 is 8 data/even/1 stop, instance 1 is 7 data/odd/2 stop.
  task automatic send_frame(input int inst, input logic [7:0] d, input logic bad_par,
                            input logic bad_stop);
    int   db;
    int   sb;
    logic p;
    db = (inst == 0) ? 8 : 7;
    sb = (inst == 0) ? 1 : 2;
    p  = (inst == 0) ? 1'b0 : 1'b1;
    for (int i = 0; i < db; i++) p ^= d[i];
    p ^= bad_par;
    drive_bit(inst, 1'b0, DIV);
    for (int i = 0; i < db; i++) drive_bit(inst, d[i], DIV);
    drive_bit(inst, p, DIV);
    for (int s = 0; s < sb; s++) drive_bit(inst, !(bad_stop && s == sb - 1), DIV);
    if (inst == 0) rxd0 = 1'b1;
    else rxd1 = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    if (bad_stop) exp_frm++;
    else if (bad_par) exp_par++;
    else if (exp_q.size() < DEPTH) begin
      exp_q.push_back(d);
      if (d == 8'h0A) exp_line++;
    end else exp_ovf++;
  endtask

  task automatic settle_and_check(input string tag);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2;
    chk({tag, "_perr"}, obs_par, exp_par);
    chk({tag, "_ferr"}, obs_frm, exp_frm);
    chk({tag, "_oerr"}, obs_ovf, exp_ovf);
    chk({tag, "_lines"}, lcnt0, exp_line);
    chk({tag, "_level"}, level0, exp_q.size());
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       bad_par;
    logic       bad_stop;
    int         dpar;
    int         dfrm;
    logic       push;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h4F, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[1] = '{8'h4B, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[2] = '{8'h0A, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[3] = '{8'h41, 1'b1, 1'b0, 1, 0, 1'b0};
    tbl[4] = '{8'h00, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[5] = '{8'hFF, 1'b0, 1'b1, 0, 1, 1'b0};
    tbl[6] = '{8'h80, 1'b1, 1'b1, 0, 1, 1'b0};
    tbl[7] = '{8'h7E, 1'b0, 1'b0, 0, 0, 1'b1};

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_valid", valid0, 0);
    chk("rst_data", data0, 0);
    chk("rst_last", last0, 0);
    chk("rst_level", level0, 0);
    chk("rst_lines", lcnt0, 0);
    chk("rst_perr", perr0, 0);
    chk("rst_ferr", ferr0, 0);
    chk("rst_oerr", oerr0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_busy7", busy1, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single 0x41, even parity bit 0, observed at FIFO head
    ready_mode = 0;
    exp_q.push_back(8'h41);
    drive_bit(0, 1'b0, DIV);
    for (int i = 0; i < 8; i++) drive_bit(0, (8'h41 >> i) & 1, DIV);
    drive_bit(0, 1'b0, DIV);
    drive_bit(0, 1'b1, 31);
    chk("t1_valid_early", valid0, 0);
    drive_bit(0, 1'b1, 39);
    chk("t1_valid", valid0, 1);
    chk("t1_data", data0, 8'h41);
    chk("t1_last", last0, 0);
    chk("t1_level", level0, 1);
    settle_and_check("t1");
    ready_mode = 1;
    repeat (4) @(negedge clk);

    // Table vectors: "OK\n", parity error, stop errors, plain characters
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].push) begin
        exp_q.push_back(tbl[i].d);
        if (tbl[i].d == 8'h0A) exp_line++;
      end
      exp_par += tbl[i].dpar;
      exp_frm += tbl[i].dfrm;
      send_frame(0, tbl[i].d, tbl[i].bad_par, tbl[i].bad_stop);
      settle_and_check($sformatf("vec%0d", i));
    end
    chk("t2_line_cnt", lcnt0, 1);

    // 0.3 us low glitch is a false start
    drive_bit(0, 1'b0, 21);
    drive_bit(0, 1'b1, 100);
    exp_frm++;
    settle_and_check("glitch");
    chk("glitch_busy", busy0, 0);

    // Overflow: 17 characters into a 16-deep FIFO with the consumer stalled
    ready_mode = 0;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 17; i++) begin
      model_frame(8'(i), 1'b0, 1'b0);
      send_frame(0, 8'(i), 1'b0, 1'b0);
      repeat (8) @(negedge clk);
    end
    settle_and_check("t4");
    chk("t4_level16", level0, 16);
    ready_mode = 1;
    for (int i = 0; i < 100 && valid0; i++) @(negedge clk);
    chk("t4_drained", valid0, 0);
    chk("t4_all_out", exp_q.size(), 0);

    // 7O2: bad second stop bit, then break held low, then a clean frame
    drive_bit(1, 1'b0, DIV);
    for (int i = 0; i < 7; i++) drive_bit(1, (7'h55 >> i) & 1, DIV);
    drive_bit(1, 1'b1, DIV);
    drive_bit(1, 1'b1, DIV);
    drive_bit(1, 1'b0, DIV);
    drive_bit(1, 1'b0, 3 * DIV);
    chk("t5_ferr", obs_frm1, 1);
    chk("t5_perr", obs_par1, 0);
    chk("t5_busy_low", busy1, 1);
    chk("t5_level", level1, 0);
    drive_bit(1, 1'b1, 1);
    for (int i = 0; i < 20 && busy1; i++) @(negedge clk);
    chk("t5_idle", busy1, 0);
    send_frame(1, 8'h55, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("t5_valid", valid1, 1);
    chk("t5_data", data1, 7'h55);
    chk("t5_ferr_total", obs_frm1, 1);

    // Reset in the middle of a frame's data bits
    ready_mode = 0;
    repeat (4) @(negedge clk);
    model_frame(8'h0A, 1'b0, 1'b0);
    send_frame(0, 8'h0A, 1'b0, 1'b0);
    settle_and_check("t6_pre");
    drive_bit(0, 1'b0, DIV);
    drive_bit(0, 1'b1, DIV);
    drive_bit(0, 1'b0, DIV / 2);
    chk("t6_busy_mid", busy0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", valid0, 0);
    chk("t6_data", data0, 0);
    chk("t6_last", last0, 0);
    chk("t6_level", level0, 0);
    chk("t6_lines", lcnt0, 0);
    chk("t6_busy", busy0, 0);
    exp_q.delete();
    exp_line = 0;
    rxd0 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    ready_mode = 1;
    model_frame(8'h5A, 1'b0, 1'b0);
    send_frame(0, 8'h5A, 1'b0, 1'b0);
    settle_and_check("t6_post");

    // Random frames with a random consumer
    ready_mode = 2;
    for (int n = 0; n < 25; n++) begin
      logic [7:0] d;
      logic       bp, bs;
      d  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) d = 8'h0A;
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0);
      model_frame(d, bp, bs);
      send_frame(0, d, bp, bs);
      drive_bit(0, 1'b1, $urandom_range(0, 60));
      settle_and_check($sformatf("rnd%0d", n));
    end
    ready_mode = 1;
    for (int i = 0; i < 100 && valid0; i++) @(negedge clk);
    chk("final_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
